// File: rtl/rv_div_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states, counter width.
package rv_div_pkg;

    localparam int DIV_K     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_K);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_cond_neg.sv
// Combinational conditional two's-complement negate: dout = neg ? -din : din.
module div_cond_neg #(
    parameter int k = 32
) (
    input  logic [k-1:0] din,
    input  logic         neg,
    output logic [k-1:0] dout
);

    always_comb begin
        dout = neg ? (~din + 1'b1) : din;
    end

endmodule

// File: rtl/rv_iter_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per cycle.
// Build option DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase entirely.
module rv_iter_divider
    import rv_div_pkg::*;
#(
    parameter int k = DIV_K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [1:0]   op,
    input  logic [k-1:0] Rs1,
    input  logic [k-1:0] Rs2,
    input  logic [4:0]   Rd_Address_in,
    output logic         ready,
    output logic         busy,
    output logic [k-1:0] Rd,
    output logic [4:0]   Rd_Address,
    output logic         write_enable
);

    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(k - 1);

    div_state_e           state_q, state_d;
    div_op_e              op_q, op_d;
    logic [4:0]           addr_q, addr_d;
    logic [k-1:0]         rem_q, rem_d;
    logic [k-1:0]         quo_q, quo_d;
    logic [k-1:0]         dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [k-1:0]         rd_q, rd_d;
    logic [4:0]           rd_addr_q, rd_addr_d;

    div_op_e      op_in;
    logic         s1, s2;
    logic [k-1:0] abs1, abs2;
    logic [k-1:0] fix_in, fix_out;
    logic         fix_neg;
    logic [k:0]   rem_sh;
    logic         take;
    logic [k-1:0] diff;

    assign op_in = div_op_e'(op);
    assign s1    = op_is_signed(op_in) & Rs1[k-1];
    assign s2    = op_is_signed(op_in) & Rs2[k-1];

    div_cond_neg #(.k(k)) u_abs_rs1 (.din(Rs1), .neg(s1), .dout(abs1));
    div_cond_neg #(.k(k)) u_abs_rs2 (.din(Rs2), .neg(s2), .dout(abs2));

    assign fix_in  = op_is_rem(op_q) ? rem_q : quo_q;
    assign fix_neg = op_is_rem(op_q) ? neg_rem_q : neg_quo_q;

    div_cond_neg #(.k(k)) u_sign_fix (.din(fix_in), .neg(fix_neg), .dout(fix_out));

    // Trial subtract: a k+1-bit compare, but the difference always fits in k bits.
    assign rem_sh = {rem_q, quo_q[k-1]};
    assign take   = (rem_sh >= {1'b0, dvs_q});
    assign diff   = rem_sh[k-1:0] - dvs_q;

    assign ready        = (state_q == IDLE);
    assign busy         = ~ready;
    assign Rd           = rd_q;
    assign Rd_Address   = rd_addr_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        div0_d       = div0_q;
        rd_d         = rd_q;
        rd_addr_d    = rd_addr_q;
        write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d      = op_in;
                    addr_d    = Rd_Address_in;
                    rem_d     = '0;
                    quo_d     = abs1;
                    dvs_d     = abs2;
                    neg_quo_d = s1 ^ s2;
                    neg_rem_d = s1;
                    div0_d    = (Rs2 == '0);
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef DIV_ZERO_FAST_EN
                    // Preload |Rs1| as the remainder so the sign fix reproduces Rs1 for REM.
                    if (Rs2 == '0) begin
                        rem_d   = abs1;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = take ? diff : rem_sh[k-1:0];
                    quo_d = {quo_q[k-2:0], take};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    // REM by zero already yields Rs1 through the datapath; only DIV needs overriding.
                    rd_d      = (div0_q && !op_is_rem(op_q)) ? '1 : fix_out;
                    rd_addr_d = addr_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                write_enable = ~flush;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= OP_DIV;
            addr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            rd_q      <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
        end
    end

endmodule
